pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
// Fetch-side controller that drives the PC register's PC_In/PCWrite inputs and runs the
// instruction-memory req/ack handshake for the IF stage of the pipelined RISC-V core.
// Issues one fetch per PC value and computes the next PC (sequential +4 or branch redirect).
// Holds the PC on load-use stalls and outstanding fetches; discards responses made stale by a redirect.
// Delivers the fetched instruction and its PC to the IF/ID register.
// PARAMETERS
// ADDR_W        64            PC / instruction address width
// INSTR_W       32            instruction width
// NOP_INSTR     32'h00000013  bubble value on if_instr (addi x0,x0,0)
// PORTS
// clk            in   1        core clock, all state on posedge
// reset          in   1        asynchronous, active-low reset (0 = reset)
// PC_Out         in   ADDR_W   current PC from the PC register
// PC_In          out  ADDR_W   next-PC value to the PC register
// PCWrite        out  1        PC register load enable
// hazard_stall   in   1        load-use stall from hazard unit
// branch_taken   in   1        redirect request (branch/jump resolved)
// branch_target  in   ADDR_W   redirect address
// imem_req       out  1        fetch request to instruction memory
// imem_addr      out  ADDR_W   fetch address, stable while imem_req=1
// imem_ack       in   1        one-cycle response strobe; imem_rdata valid in same cycle
// imem_rdata     in   INSTR_W  fetched instruction
// if_valid       out  1        if_instr/if_pc hold a real instruction
// if_instr       out  INSTR_W  instruction to IF/ID
// if_pc          out  ADDR_W   PC of if_instr
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, imem_req=0, imem_addr=0, if_valid=0, if_instr=NOP_INSTR,
//   if_pc=0, hold_buf=0. While reset=0: PCWrite=0, PC_In=0.
// - PC_In/PCWrite are combinational from state and inputs; all other outputs are registered.
// - Sequential next PC: PC_Out+4, modulo 2^ADDR_W; 'hFF..FC wraps to 0. No carry out.
// - imem protocol: imem_req rises with imem_addr latched from PC_Out.
//   Req and addr then stay constant until the cycle imem_ack=1; req drops on the edge after ack.
//   ack is never sampled while req=0. Earliest ack is the cycle after req rises.
// - Priority per cycle: branch_taken > hazard_stall > imem_ack.
// - States:
//   IDLE:  first cycle after reset release; PCWrite=0. -> FETCH, raise req at PC_Out.
//   FETCH: req outstanding.
//     branch_taken: PCWrite=1, PC_In=branch_target, if_valid<=0, if_instr<=NOP.
//       With ack: drop data, re-request at new PC next cycle; stay FETCH. Without ack: -> DROP.
//     ack & stall: hold_buf<=rdata, req<=0, PCWrite=0, IF/ID outputs held; -> HOLD.
//     ack & !stall: if_instr<=rdata, if_pc<=imem_addr, if_valid<=1, PCWrite=1, PC_In=PC_Out+4.
//       New req issued next cycle at the new PC; stay FETCH.
//     no ack: PCWrite=0. if_valid<=0 unless hazard_stall=1 (then outputs hold).
//   HOLD:  data buffered, req=0.
//     branch_taken: discard hold_buf, redirect as above; -> FETCH.
//     stall=1: hold everything.
//     stall=0: deliver hold_buf as in ack&!stall, PCWrite=1, PC_In=PC_Out+4; -> FETCH.
//   DROP:  stale req still pending, same addr.
//     Next ack: data discarded, if_valid stays 0, -> FETCH at current PC_Out.
//     Further branch_taken in DROP: PCWrite=1, PC_In=branch_target; stay DROP.
// - PCWrite=0 on every cycle not listed above.
//   Exactly one PC advance per delivered instruction or redirect.
// - Reset asserted mid-fetch: outstanding req abandoned; memory must tolerate req dropping without ack.
// TESTING
// 1. Reset release, PC_Out=0, ack 1 cycle after req, rdata=0x00500093
//    -> if_instr=0x00500093, if_pc=0, PCWrite pulse with PC_In=4, next imem_addr=4.
// 2. Ack latency 3 cycles at PC=0x10 -> imem_addr=0x10 held 3 cycles, PCWrite=0 throughout;
//    if_valid=0 until delivery, then if_pc=0x10, PC_In=0x14.
// 3. Branch while fetch at 0x20 outstanding, branch_target=0x100 -> PCWrite=1, PC_In=0x100, enter DROP;
//    ack for 0x20 discarded (if_valid=0); next req at 0x100.
// 4. hazard_stall=1 when ack at 0x40 (rdata=0xABCD0013) -> PCWrite=0, if_* held, HOLD for 2 cycles;
//    stall drops -> if_instr=0xABCD0013, if_pc=0x40, PC_In=0x44.
// 5. PC_Out='hFFFF_FFFF_FFFF_FFFC, ack -> PC_In=0, next imem_addr=0.
// 6. Branch and ack same cycle; separately, reset=0 mid-request
//    -> ack data dropped, req at target next cycle; reset forces req=0, if_valid=0, PCWrite=0 immediately.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: IF-stage fetch controller.
// Drives the PC register, runs the imem req/ack handshake and feeds IF/ID.
module pc_fetch_sequencer #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  PC_Out,
    output logic [ADDR_W-1:0]  PC_In,
    output logic               PCWrite,
    input  logic               hazard_stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DROP
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_t             state;
    state_t             state_n;
    logic [INSTR_W-1:0] hold_buf;
    logic               ack_hit;

    assign ack_hit = imem_req && imem_ack;

    // Next state plus the combinational PC register controls.
    always_comb begin
        state_n = state;
        PCWrite = 1'b0;
        PC_In   = '0;
        if (reset) begin
            unique case (state)
                IDLE: state_n = FETCH;
                FETCH: begin
                    if (branch_taken) begin
                        PCWrite = 1'b1;
                        PC_In   = branch_target;
                        if (imem_req && !imem_ack) state_n = DROP;
                    end else if (ack_hit && hazard_stall) begin
                        state_n = HOLD;
                    end else if (ack_hit) begin
                        PCWrite = 1'b1;
                        PC_In   = PC_Out + PC_STEP;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        PCWrite = 1'b1;
                        PC_In   = branch_target;
                        state_n = FETCH;
                    end else if (!hazard_stall) begin
                        PCWrite = 1'b1;
                        PC_In   = PC_Out + PC_STEP;
                        state_n = FETCH;
                    end
                end
                DROP: begin
                    if (branch_taken) begin
                        PCWrite = 1'b1;
                        PC_In   = branch_target;
                    end
                    if (imem_ack) state_n = FETCH;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Request, hold buffer and IF/ID output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_req  <= 1'b0;
            imem_addr <= '0;
            if_valid  <= 1'b0;
            if_instr  <= NOP_INSTR;
            if_pc     <= '0;
            hold_buf  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    imem_req  <= 1'b1;
                    imem_addr <= PC_Out;
                end
                FETCH: begin
                    if (branch_taken) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                        if (imem_ack) imem_req <= 1'b0;
                    end else if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= PC_Out;
                        if (!hazard_stall) if_valid <= 1'b0;
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (hazard_stall) begin
                            hold_buf <= imem_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_instr <= imem_rdata;
                            if_pc    <= imem_addr;
                        end
                    end else if (!hazard_stall) begin
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                    end else if (!hazard_stall) begin
                        if_valid <= 1'b1;
                        if_instr <= hold_buf;
                        if_pc    <= imem_addr;
                    end
                end
                DROP: begin
                    if (branch_taken) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                    end
                    if (imem_ack) imem_req <= 1'b0;
                end
                default: imem_req <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed bench with a transaction-level model.
// The bench owns the PC register and the instruction memory responses.
module tb_pc_fetch_sequencer;

    localparam int AW = 64;
    localparam int IW = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] PC_Out;
    logic [AW-1:0] PC_In;
    logic          PCWrite;
    logic          hazard_stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          if_valid;
    logic [IW-1:0] if_instr;
    logic [AW-1:0] if_pc;

    int vectors = 0;
    int miscompares = 0;

    // Model: fetch slot, stale flag, buffered word, IF/ID contents.
    bit            in_rst;
    bit            m_started;
    bit            m_req;
    bit            m_stale;
    bit            m_bufv;
    bit            m_valid;
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_pc;
    logic [IW-1:0] m_buf;
    logic [IW-1:0] m_instr;
    bit            e_we;
    logic [AW-1:0] e_nxt;

    pc_fetch_sequencer #(
        .ADDR_W(AW),
        .INSTR_W(IW),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .PC_Out(PC_Out),
        .PC_In(PC_In),
        .PCWrite(PCWrite),
        .hazard_stall(hazard_stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid),
        .if_instr(if_instr),
        .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // PC advances once per redirect or per word handed to IF/ID.
    task automatic compare_all();
        e_we  = 1'b0;
        e_nxt = '0;
        if (!in_rst && m_started) begin
            if (branch_taken) begin
                e_we  = 1'b1;
                e_nxt = branch_target;
            end else if (!hazard_stall &&
                         ((m_req && imem_ack && !m_stale) || m_bufv)) begin
                e_we  = 1'b1;
                e_nxt = PC_Out + 64'd4;
            end
        end
        chk("PCWrite", 64'(PCWrite), 64'(e_we));
        chk("PC_In", PC_In, e_nxt);
        chk("imem_req", 64'(imem_req), 64'(m_req));
        chk("imem_addr", imem_addr, m_addr);
        chk("if_valid", 64'(if_valid), 64'(m_valid));
        chk("if_instr", 64'(if_instr), 64'(m_instr));
        chk("if_pc", if_pc, m_pc);
    endtask

    task automatic deliver(input logic [IW-1:0] d);
        m_valid = 1'b1;
        m_instr = d;
        m_pc    = m_addr;
    endtask

    task automatic model_step();
        if (!m_started) begin
            m_started = 1'b1;
            m_req     = 1'b1;
            m_addr    = PC_Out;
        end else if (branch_taken) begin
            m_valid = 1'b0;
            m_instr = NOP;
            m_bufv  = 1'b0;
            if (m_req && !imem_ack) begin
                m_stale = 1'b1;
            end else begin
                m_req   = 1'b0;
                m_stale = 1'b0;
            end
        end else if (m_req && imem_ack) begin
            m_req = 1'b0;
            if (m_stale) begin
                m_stale = 1'b0;
            end else if (hazard_stall) begin
                m_bufv = 1'b1;
                m_buf  = imem_rdata;
            end else begin
                deliver(imem_rdata);
            end
        end else if (m_bufv) begin
            if (!hazard_stall) begin
                deliver(m_buf);
                m_bufv = 1'b0;
            end
        end else if (m_req) begin
            if (!m_stale && !hazard_stall) m_valid = 1'b0;
        end else begin
            m_req  = 1'b1;
            m_addr = PC_Out;
            if (!hazard_stall) m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit st, input bit br, input logic [63:0] tgt,
                        input bit ack, input logic [31:0] rd);
        hazard_stall  = st;
        branch_taken  = br;
        branch_target = tgt;
        imem_ack      = ack;
        imem_rdata    = rd;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        model_step();
        if (e_we) PC_Out = e_nxt;
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic do_reset(input logic [63:0] start);
        reset         = 1'b0;
        in_rst        = 1'b1;
        hazard_stall  = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        PC_Out        = start;
        m_started     = 1'b0;
        m_req         = 1'b0;
        m_stale       = 1'b0;
        m_bufv        = 1'b0;
        m_valid       = 1'b0;
        m_addr        = '0;
        m_pc          = '0;
        m_buf         = '0;
        m_instr       = NOP;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        in_rst = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        PC_Out        = '0;
        hazard_stall  = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        @(posedge clk);
        #1;

        // single-cycle ack at PC 0
        do_reset(64'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0050_0093);
        chk("t1_instr", 64'(if_instr), 64'h0050_0093);
        chk("t1_pc", if_pc, 64'h0);
        chk("t1_valid", 64'(if_valid), 64'h1);
        step(0, 0, 0, 0, 0);
        chk("t1_next_addr", imem_addr, 64'h4);
        chk("t1_next_req", 64'(imem_req), 64'h1);

        // three-cycle ack latency at 0x10
        do_reset(64'h10);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("t2_addr_held", imem_addr, 64'h10);
        end
        step(0, 0, 0, 1, 32'h1111_1113);
        chk("t2_pc", if_pc, 64'h10);
        step(0, 0, 0, 0, 0);
        chk("t2_next_addr", imem_addr, 64'h14);

        // redirect with outstanding fetch, then redirect inside drop
        do_reset(64'h20);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 64'h100, 0, 0);
        chk("t3_req_kept", 64'(imem_req), 64'h1);
        step(0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("t3_stale_valid", 64'(if_valid), 64'h0);
        step(0, 0, 0, 0, 0);
        chk("t3_new_addr", imem_addr, 64'h100);
        step(0, 1, 64'h300, 0, 0);
        step(1, 1, 64'h380, 0, 0);
        step(0, 0, 0, 1, 32'hBAD0_0013);
        step(0, 0, 0, 0, 0);
        chk("t3_drop_addr", imem_addr, 64'h380);
        step(0, 0, 0, 1, 32'h2222_2213);
        chk("t3_instr", 64'(if_instr), 64'h2222_2213);

        // load-use stall on ack at 0x40
        do_reset(64'h40);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'hABCD_0013);
        chk("t4_held_valid", 64'(if_valid), 64'h0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t4_req_low", 64'(imem_req), 64'h0);
        step(0, 0, 0, 0, 0);
        chk("t4_instr", 64'(if_instr), 64'hABCD_0013);
        chk("t4_pc", if_pc, 64'h40);
        step(1, 0, 0, 0, 0);
        chk("t4_stall_valid", 64'(if_valid), 64'h1);
        chk("t4_next_addr", imem_addr, 64'h44);

        // PC wrap at the top of the address space
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h3333_3313);
        step(0, 0, 0, 0, 0);
        chk("t5_wrap_addr", imem_addr, 64'h0);

        // redirect and ack together, then reset mid-request
        do_reset(64'h80);
        step(0, 0, 0, 0, 0);
        step(0, 1, 64'h200, 1, 32'h4444_4413);
        chk("t6_valid", 64'(if_valid), 64'h0);
        chk("t6_req", 64'(imem_req), 64'h0);
        step(0, 0, 0, 0, 0);
        chk("t6_addr", imem_addr, 64'h200);
        step(0, 0, 0, 1, 32'h5555_5513);
        step(1, 0, 0, 0, 0);
        hazard_stall = 1'b0;
        branch_taken = 1'b1;
        branch_target = 64'h400;
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_req", 64'(imem_req), 64'h0);
        chk("t6_rst_valid", 64'(if_valid), 64'h0);
        chk("t6_rst_we", 64'(PCWrite), 64'h0);
        chk("t6_rst_pcin", PC_In, 64'h0);
        @(posedge clk);
        #1;
        do_reset(64'h600);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h6666_6613);
        chk("t6_after_pc", if_pc, 64'h600);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
